// File: rtl/moore_fsm_pkg.sv
// Shared types and helpers for the parametrised Moore pattern detector.
// Optional don't-care masking is enabled with PATTERN_FSM_MASK_EN.
package moore_fsm_pkg;

  typedef enum logic {
    MODE_NONOVL  = 1'b0,
    MODE_OVERLAP = 1'b1
  } mode_e;

  localparam int DEF_PAT_LEN = 4;
  localparam int DEF_CNT_W   = 8;

  function automatic int st_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // All-ones value of a w-bit counter (32-bit wrap makes w=32 come out right).
  function automatic int unsigned sat_value(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pattern_next_state.sv
// Combinational next-state logic: prefix-suffix (KMP) search over the last
// consumed bits, plus the non-overlapping restart after a full match.
module pattern_next_state
  import moore_fsm_pkg::*;
#(
  parameter  int PAT_LEN = DEF_PAT_LEN,
  localparam int ST_W    = st_width(PAT_LEN)
) (
  input  logic [ST_W-1:0]    state,
  input  logic [PAT_LEN-2:0] history,
  input  logic               in,
  input  logic [PAT_LEN-1:0] pattern,
  input  mode_e              overlap,
  input  logic [PAT_LEN-1:0] mask,
  output logic [ST_W-1:0]    next_state
);

  localparam logic [ST_W-1:0] FULL = ST_W'(PAT_LEN);

  logic [PAT_LEN-1:0] window;
  logic               ok;
  int unsigned        lim;

  always_comb begin
    window     = {history, in};
    next_state = '0;
    ok         = 1'b0;
    lim        = (state >= FULL) ? PAT_LEN : 32'(state) + 32'd1;
    if (overlap == MODE_OVERLAP || state < FULL) begin
      // Ascending j, so the last hit is the longest prefix that is also a suffix.
      for (int unsigned j = 1; j <= PAT_LEN; j++) begin
        ok = (j <= lim);
        for (int unsigned k = 0; k < j; k++) begin
          if (!mask[PAT_LEN-1-k] && (window[j-1-k] != pattern[PAT_LEN-1-k]))
            ok = 1'b0;
        end
        if (ok)
          next_state = ST_W'(j);
      end
    end else begin
      next_state = (in == pattern[PAT_LEN-1] || mask[PAT_LEN-1]) ? ST_W'(1) : '0;
    end
  end

endmodule

// File: rtl/moore_pattern_fsm.sv
// Moore serial pattern detector with run-time loadable pattern and match counter.
// Define PATTERN_FSM_MASK_EN to add the cfg_mask don't-care port.
module moore_pattern_fsm
  import moore_fsm_pkg::*;
#(
  parameter  int PAT_LEN = DEF_PAT_LEN,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int ST_W    = st_width(PAT_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in,
  input  logic               cfg_we,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
`ifdef PATTERN_FSM_MASK_EN
  input  logic [PAT_LEN-1:0] cfg_mask,
`endif
  output logic [ST_W-1:0]    state,
  output logic               detect,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int              HIST_W  = PAT_LEN - 1;
  localparam logic [ST_W-1:0] FULL    = ST_W'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(sat_value(CNT_W));

  logic [PAT_LEN-1:0] pattern_q;
  logic [HIST_W-1:0]  history_q;
  logic [PAT_LEN-1:0] mask_q;
  mode_e              mode_q;
  logic [ST_W-1:0]    next_state;

  pattern_next_state #(
    .PAT_LEN (PAT_LEN)
  ) u_next (
    .state      (state),
    .history    (history_q),
    .in         (in),
    .pattern    (pattern_q),
    .overlap    (mode_q),
    .mask       (mask_q),
    .next_state (next_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      mode_q    <= MODE_OVERLAP;
      history_q <= '0;
      state     <= '0;
      match_cnt <= '0;
    end else if (cfg_we) begin
      pattern_q <= cfg_pattern;
      mode_q    <= mode_e'(cfg_overlap);
      history_q <= '0;
      state     <= '0;
      match_cnt <= '0;
    end else if (en) begin
      history_q <= HIST_W'({history_q, in});
      state     <= next_state;
      if (next_state == FULL && match_cnt != CNT_SAT)
        match_cnt <= match_cnt + 1'b1;
    end
  end

`ifdef PATTERN_FSM_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mask_q <= '0;
    else if (cfg_we)
      mask_q <= cfg_mask;
  end
`else
  assign mask_q = '0;
`endif

  assign detect = (state == FULL);

endmodule

// File: doc/moore_pattern_fsm.md
Name: moore_pattern_fsm

Overview:
Parametrised Moore-style serial pattern detector, successor to the fixed 6-state Moore machine.
- Detects a run-time loadable PAT_LEN-bit pattern on a 1-bit input stream.
- Supports overlapping and non-overlapping detection, and counts matches.
- Used by lab-level top modules as a reusable sequence recogniser driven from switches or debounced buttons.

Parameters:
PAT_LEN, 4, pattern length in bits (2..16).
CNT_W, 8, width of the saturating match counter.
ST_W, $clog2(PAT_LEN+1), state width (derived localparam, not overridable).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  sample qualifier; in is consumed only when en=1.
in  input  1  serial data bit.
cfg_we  input  1  load pattern and mode.
cfg_pattern  input  PAT_LEN  pattern; MSB is the first bit expected.
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
state  output  ST_W  current state = number of pattern bits matched (0..PAT_LEN).
detect  output  1  high while state==PAT_LEN (Moore output).
match_cnt  output  CNT_W  number of detections, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - state=0, detect=0, match_cnt=0.
  - Internal pattern register = all zeros, overlap=1, history register=0.
- Registered internals: pattern reg, overlap reg, state reg, and a history shift reg of the last PAT_LEN-1 consumed bits.
- cfg_we=1 at posedge:
  - Load pattern and overlap.
  - Force state=0, clear history and match_cnt.
  - cfg_we has priority over en; the concurrent in bit is discarded.
- en=0: all registers hold.
- en=1, cfg_we=0: consume in, shift it into history. Next state s' is computed from current state s:
  - Overlap mode, or s<PAT_LEN: s' = largest j in 0..min(s+1,PAT_LEN) such that the last j consumed bits (newest = in) equal pattern bits [PAT_LEN-1 : PAT_LEN-j]. This is the prefix-suffix (KMP) rule.
  - Non-overlap mode with s==PAT_LEN: restart. s' = 1 if in==pattern[PAT_LEN-1], else 0.
- detect is combinational from the state register only; it never depends on in. It is high exactly one cycle per detection unless the next bit re-enters PAT_LEN.
- Latency: detect rises on the clock edge that consumes the final pattern bit.
- match_cnt increments on every edge where s'==PAT_LEN and en=1. Saturates at 2^CNT_W-1 with no wrap.
- Reset mid-stream clears state and count immediately and asynchronously; the first valid bit after release is treated as stream start.
- With an all-zero default pattern, a run of zeros detects every cycle after PAT_LEN bits in overlap mode.

Optional Feature:
PATTERN_FSM_MASK_EN
- Defined:
  - Adds port cfg_mask (input, PAT_LEN), loaded with cfg_we; reset value 0.
  - Pattern positions whose mask bit is 1 are don't-care and match either input value, in both the KMP comparison and the non-overlap restart.
- Undefined: port absent; every bit is compared exactly. RTL must be identical to a mask of all zeros.

Decomposition:
- Package moore_fsm_pkg:
  - Function clog2-based ST_W helper.
  - Localparam for counter saturation value.
  - Enum-like constants MODE_OVERLAP=1'b1, MODE_NONOVL=1'b0.
- One natural sub-module, pattern_next_state:
  - Purely combinational; inputs state, history, in, pattern, overlap (and mask); output next state.
  - Contains the prefix-suffix loop over j.
  - The top holds the registers, counter and config capture.

Test Plan:
1. PAT_LEN=4, load 1011, overlap=1, stream 1,0,1,1,0,1,1 (en=1) -> state 1,2,3,4,2,3,4; detect high after bits 4 and 7; match_cnt=2.
2. Same stream with overlap=0 -> state 1,2,3,4,0,1,1; detect only after bit 4; match_cnt=1.
3. Load 1011, stream 1,0,1,0,1,1 -> state 1,2,3,2,3,4; detect once; verifies the 3->2 fallback on mismatch.
4. Load 0000 with CNT_W=2, overlap=1, 10 zeros -> detect high from bit 4 to bit 10; match_cnt saturates at 3.
5. Mid-pattern (state=3): pulse cfg_we with en=1 -> state=0, match_cnt=0, in bit ignored. Then async rst_n low between edges -> outputs 0 immediately, without waiting for a clock.
6. PATTERN_FSM_MASK_EN defined, pattern 1001, mask 0110, stream 1,1,1,1 -> detect after bit 4, match_cnt=1. With mask=0 -> no detect.
